// File: rtl/uart_tx_param_if.sv
// rtl/uart_tx_param_if.sv - producer-side word handshake into the buffered UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 txValid;
  logic                 txReady;

  modport master (output data, output txValid, input txReady);
  modport slave  (input data, input txValid, output txReady);
endinterface

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - buffered UART transmitter with configurable width, parity and stop bits.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  uart_tx_param_if.slave                    bus,
  output logic                              tx,
  output logic                              txActive,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoCount
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] RELOAD    = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;

  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 active_q, active_d;
  logic                 tick;

  // Ready comes from the registered count only, so a same-cycle pop never opens a slot early.
  assign ready       = (count_q != CW'(FIFO_DEPTH));
  assign bus.txReady = ready;
  assign push        = bus.txValid && ready;
  assign empty       = (count_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign head_parity = (PARITY == 1) ? ~(^head) : (^head);
  assign tick        = (timer_q == '0);

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    active_d   = active_q;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d     = 1'b1;
        active_d = 1'b0;
        timer_d  = '0;
        if (!empty) begin
          pop = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          timer_d   = RELOAD;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          timer_d = RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          timer_d    = RELOAD;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              tx_d     = 1'b1;
              active_d = 1'b0;
              state_d  = S_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            timer_d    = RELOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        tx_d     = 1'b1;
        active_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase

    // A pop from either IDLE or the final STOP clock starts the next frame with no gap.
    if (pop) begin
      shift_d  = head;
      parity_d = head_parity;
      timer_d  = RELOAD;
      tx_d     = 1'b0;
      active_d = 1'b1;
      state_d  = S_START;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
    end
  end

  assign tx        = tx_q;
  assign txActive  = active_q;
  assign fifoCount = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - directed bench: 8N1 core plus 7O1 and 7E2 instances, all at 4 clocks per bit.
module tb_uart_tx_param;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  uart_tx_param_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_param_if #(.DATA_BITS(7)) bus1 ();
  uart_tx_param_if #(.DATA_BITS(7)) bus2 ();

  logic       tx0, tx1, tx2;
  logic       act0, act1, act2;
  logic [2:0] cnt0, cnt1, cnt2;

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u0 (
    .clock(clock), .reset(reset), .bus(bus0), .tx(tx0), .txActive(act0), .fifoCount(cnt0));
  uart_tx_param #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u1 (
    .clock(clock), .reset(reset), .bus(bus1), .tx(tx1), .txActive(act1), .fifoCount(cnt1));
  uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u2 (
    .clock(clock), .reset(reset), .bus(bus2), .tx(tx2), .txActive(act2), .fifoCount(cnt2));

  // Receiver for the 8N1 instance: samples each bit in its third clock and logs frame start cycles.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  int         frame_err = 0;

  initial begin
    int         m_state;
    int         m_cnt;
    int         b;
    logic [7:0] m_word;
    m_state = 0;
    m_cnt   = 0;
    m_word  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        m_state = 0;
      end else begin
        if (m_state == 0 && tx0 == 1'b0) begin
          m_state = 1;
          m_cnt   = -1;
          m_word  = '0;
          rx_start.push_back(cyc);
        end
        if (m_state == 1) begin
          m_cnt++;
          if (m_cnt % 4 == 2) begin
            b = m_cnt / 4;
            if (b == 0 && tx0 !== 1'b0) frame_err++;
            if (b >= 1 && b <= 8) m_word[b-1] = tx0;
            if (b == 9 && tx0 !== 1'b1) frame_err++;
          end
          if (m_cnt == 39) begin
            rx_q.push_back(m_word);
            m_state = 0;
          end
        end
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus0.txValid = 1'b0; bus1.txValid = 1'b0; bus2.txValid = 1'b0;
    bus0.data = '0; bus1.data = '0; bus2.data = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (tx0 !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx0); end
    n_cmp++; if (act0 !== 1'b0) begin n_bad++; $display("FAIL reset_active got %b want 0", act0); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", cnt0); end
    n_cmp++; if (bus0.txReady !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus0.txReady); end
    n_cmp++; if ({tx1, tx2, act1, act2} !== 4'b1100) begin n_bad++; $display("FAIL reset_parity_insts got %b want 1100", {tx1, tx2, act1, act2}); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic_frame();
    logic [9:0]  frame;
    logic [43:0] obs_tx, obs_act, exp_tx, exp_act;
    frame = {1'b1, 8'h55, 1'b0};
    for (int t = 0; t < 44; t++) begin
      exp_tx[t]  = (t < 40) ? frame[t/4] : 1'b1;
      exp_act[t] = (t < 40);
    end
    clear_rx();
    bus0.data = 8'h55; bus0.txValid = 1'b1;
    @(posedge clock); #1;
    bus0.txValid = 1'b0;
    @(negedge clock);
    n_cmp++; if (tx0 !== 1'b1) begin n_bad++; $display("FAIL basic_tx_after_push got %b want 1", tx0); end
    n_cmp++; if (cnt0 !== 3'd1) begin n_bad++; $display("FAIL basic_count_after_push got %0d want 1", cnt0); end
    for (int t = 0; t < 44; t++) begin
      @(negedge clock);
      obs_tx[t]  = tx0;
      obs_act[t] = act0;
      if (t == 0) begin
        n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL basic_count_after_pop got %0d want 0", cnt0); end
      end
    end
    n_cmp++; if (obs_tx !== exp_tx) begin n_bad++; $display("FAIL basic_tx_wave got %h want %h", obs_tx, exp_tx); end
    n_cmp++; if (obs_act !== exp_act) begin n_bad++; $display("FAIL basic_active_wave got %h want %h", obs_act, exp_act); end
    repeat (4) @(negedge clock);
  endtask

  task automatic test_parity(input logic [6:0] w, input logic exp_odd, input logic exp_even);
    logic [59:0] s1, s2;
    logic [6:0]  d1, d2;
    int          a1, a2;
    a1 = 0; a2 = 0;
    bus1.data = w; bus2.data = w;
    bus1.txValid = 1'b1; bus2.txValid = 1'b1;
    @(posedge clock); #1;
    bus1.txValid = 1'b0; bus2.txValid = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clock);
      s1[t] = tx1; s2[t] = tx2;
      if (act1) a1++;
      if (act2) a2++;
    end
    for (int i = 0; i < 7; i++) begin
      d1[i] = s1[4*(i+1)+2];
      d2[i] = s2[4*(i+1)+2];
    end
    n_cmp++; if ({s1[2], s2[2]} !== 2'b00) begin n_bad++; $display("FAIL parity_start got %b want 00", {s1[2], s2[2]}); end
    n_cmp++; if (d1 !== w) begin n_bad++; $display("FAIL odd_data got %h want %h", d1, w); end
    n_cmp++; if (s1[34] !== exp_odd) begin n_bad++; $display("FAIL odd_parity_bit got %b want %b", s1[34], exp_odd); end
    n_cmp++; if (s1[38] !== 1'b1) begin n_bad++; $display("FAIL odd_stop got %b want 1", s1[38]); end
    n_cmp++; if (a1 != 40) begin n_bad++; $display("FAIL odd_active_len got %0d want 40", a1); end
    n_cmp++; if (d2 !== w) begin n_bad++; $display("FAIL even_data got %h want %h", d2, w); end
    n_cmp++; if (s2[34] !== exp_even) begin n_bad++; $display("FAIL even_parity_bit got %b want %b", s2[34], exp_even); end
    n_cmp++; if ({s2[38], s2[42]} !== 2'b11) begin n_bad++; $display("FAIL even_stops got %b want 11", {s2[38], s2[42]}); end
    n_cmp++; if (a2 != 44) begin n_bad++; $display("FAIL even_active_len got %0d want 44", a2); end
  endtask

  task automatic test_burst_full();
    int drops;
    drops = 0;
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      bus0.data = 8'hA1 + 8'(i); bus0.txValid = 1'b1;
      @(posedge clock); #1;
    end
    bus0.txValid = 1'b0;
    @(negedge clock);
    n_cmp++; if (cnt0 !== 3'd4) begin n_bad++; $display("FAIL burst_count_full got %0d want 4", cnt0); end
    n_cmp++; if (bus0.txReady !== 1'b0) begin n_bad++; $display("FAIL burst_ready_full got %b want 0", bus0.txReady); end
    for (int k = 0; k < 400 && rx_q.size() < 5; k++) begin
      @(negedge clock); #1;
      if (!act0) drops++;
    end
    n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL burst_rx_count got %0d want 5", rx_q.size()); end
    n_cmp++; if (drops != 0) begin n_bad++; $display("FAIL burst_active_drops got %0d want 0", drops); end
    for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== 8'hA1 + 8'(i)) begin n_bad++; $display("FAIL burst_word%0d got %h want %h", i, rx_q[i], 8'hA1 + 8'(i)); end
    end
    for (int i = 0; i < 4 && i + 1 < rx_start.size(); i++) begin
      n_cmp++; if (rx_start[i+1] - rx_start[i] != 40) begin n_bad++; $display("FAIL burst_spacing%0d got %0d want 40", i, rx_start[i+1] - rx_start[i]); end
    end
    repeat (60) @(negedge clock);
    #1;
    n_cmp++; if (rx_q.size() != 5) begin n_bad++; $display("FAIL burst_no_extra got %0d want 5", rx_q.size()); end
    n_cmp++; if (act0 !== 1'b0) begin n_bad++; $display("FAIL burst_idle_after got %b want 0", act0); end
  endtask

  task automatic test_simul_push_pop();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'hB1; exp_w[1] = 8'hB2; exp_w[2] = 8'hB3; exp_w[3] = 8'hB4;
    clear_rx();
    for (int e = 1; e <= 42; e++) begin
      if (e <= 3 || e == 42) begin
        bus0.data = (e == 42) ? 8'hB4 : 8'hB0 + 8'(e);
        bus0.txValid = 1'b1;
      end else begin
        bus0.txValid = 1'b0;
      end
      @(posedge clock); #1;
      if (e == 41) begin
        @(negedge clock);
        n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL simul_count_before got %0d want 2", cnt0); end
        n_cmp++; if (tx0 !== 1'b1) begin n_bad++; $display("FAIL simul_last_stop got %b want 1", tx0); end
      end
    end
    bus0.txValid = 1'b0;
    @(negedge clock);
    n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL simul_count_after got %0d want 2", cnt0); end
    n_cmp++; if (tx0 !== 1'b0) begin n_bad++; $display("FAIL simul_next_start got %b want 0", tx0); end
    for (int k = 0; k < 300 && rx_q.size() < 4; k++) begin
      @(negedge clock); #1;
    end
    n_cmp++; if (rx_q.size() != 4) begin n_bad++; $display("FAIL simul_rx_count got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== exp_w[i]) begin n_bad++; $display("FAIL simul_word%0d got %h want %h", i, rx_q[i], exp_w[i]); end
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] words [3];
    int         lows;
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h3C;
    lows = 0;
    clear_rx();
    for (int e = 1; e <= 18; e++) begin
      if (e <= 3) begin
        bus0.data = words[e-1]; bus0.txValid = 1'b1;
      end else begin
        bus0.txValid = 1'b0;
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    n_cmp++; if (cnt0 !== 3'd2) begin n_bad++; $display("FAIL midrst_queued got %0d want 2", cnt0); end
    n_cmp++; if (tx0 !== 1'b0) begin n_bad++; $display("FAIL midrst_bit3 got %b want 0", tx0); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_cmp++; if (tx0 !== 1'b1) begin n_bad++; $display("FAIL midrst_tx got %b want 1", tx0); end
    n_cmp++; if (act0 !== 1'b0) begin n_bad++; $display("FAIL midrst_active got %b want 0", act0); end
    n_cmp++; if (cnt0 !== 3'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", cnt0); end
    n_cmp++; if (bus0.txReady !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b want 1", bus0.txReady); end
    reset = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (tx0 !== 1'b1 || act0 !== 1'b0) lows++;
    end
    #1;
    n_cmp++; if (lows != 0) begin n_bad++; $display("FAIL midrst_silent got %0d want 0", lows); end
    n_cmp++; if (rx_q.size() != 0) begin n_bad++; $display("FAIL midrst_rx_count got %0d want 0", rx_q.size()); end
  endtask

  task automatic test_pointer_wrap();
    int   idx;
    logic v, acc;
    idx = 0;
    clear_rx();
    for (int k = 0; k < 3000 && idx < 12; k++) begin
      v = 1'($urandom_range(0, 1));
      bus0.data = 8'(idx);
      bus0.txValid = v;
      acc = v && bus0.txReady;
      @(posedge clock); #1;
      if (acc) idx++;
    end
    bus0.txValid = 1'b0;
    n_cmp++; if (idx != 12) begin n_bad++; $display("FAIL wrap_pushed got %0d want 12", idx); end
    for (int k = 0; k < 1000 && rx_q.size() < 12; k++) begin
      @(negedge clock); #1;
    end
    n_cmp++; if (rx_q.size() != 12) begin n_bad++; $display("FAIL wrap_rx_count got %0d want 12", rx_q.size()); end
    for (int i = 0; i < 12 && i < rx_q.size(); i++) begin
      n_cmp++; if (rx_q[i] !== 8'(i)) begin n_bad++; $display("FAIL wrap_word%0d got %h want %h", i, rx_q[i], 8'(i)); end
    end
    n_cmp++; if (frame_err != 0) begin n_bad++; $display("FAIL framing_errors got %0d want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity(7'h41, 1'b1, 1'b0);
    test_parity(7'h07, 1'b0, 1'b1);
    test_burst_full();
    test_simul_push_pop();
    test_reset_mid_frame();
    test_pointer_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
